// File: rtl/button_debounce_scen_pkg.sv
// button_debounce_scen_pkg: shared one-hot state encoding and counter sizing for button input stages
package button_debounce_scen_pkg;

    typedef enum logic [6:0] {
        ST_INIT   = 7'b0000001,
        ST_WQ     = 7'b0000010,
        ST_SCEN   = 7'b0000100,
        ST_HOLD   = 7'b0001000,
        ST_MCEN   = 7'b0010000,
        ST_REPEAT = 7'b0100000,
        ST_WFQ    = 7'b1000000
    } state_t;

    // Width of a counter that must reach the largest of three terminal counts minus one
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/button_debounce_scen_debounce_channel.sv
// debounce_channel: synchroniser, debounce FSM and repeat counter for a single push-button
module debounce_channel
    import button_debounce_scen_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic dpb,
    output logic scen,
    output logic mcen
);

    localparam int CW = cnt_width(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CW-1:0] DEB_END = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] DLY_END = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RPT_END = CW'(REPEAT_RATE - 1);

    logic [1:0]    sync_q, sync_d;
    logic          s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          dpb_q, dpb_d, scen_q, scen_d, mcen_q, mcen_d;

    assign s       = sync_q[1];
    assign cnt_inc = cnt_q + 1'b1;
    assign dpb     = dpb_q;
    assign scen    = scen_q;
    assign mcen    = mcen_q;

    // Next state, counter and outputs; outputs decode the current state so they lag it by one edge
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        state_d = state_q;
        cnt_d   = cnt_inc;
        case (state_q)
            ST_INIT: begin
                state_d = s ? ST_WQ : ST_INIT;
                cnt_d   = '0;
            end
            ST_WQ: begin
                state_d = !s ? ST_INIT : (cnt_q == DEB_END) ? ST_SCEN : ST_WQ;
                cnt_d   = (!s || cnt_q == DEB_END) ? '0 : cnt_inc;
            end
            ST_SCEN: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
            ST_HOLD: begin
                state_d = !s ? ST_WFQ : (cnt_q == DLY_END) ? ST_MCEN : ST_HOLD;
                cnt_d   = (!s || cnt_q == DLY_END) ? '0 : cnt_inc;
            end
            ST_MCEN: begin
                state_d = ST_REPEAT;
                cnt_d   = '0;
            end
            ST_REPEAT: begin
                state_d = !s ? ST_WFQ : (cnt_q == RPT_END) ? ST_MCEN : ST_REPEAT;
                cnt_d   = (!s || cnt_q == RPT_END) ? '0 : cnt_inc;
            end
            ST_WFQ: begin
                state_d = (!s && cnt_q == DEB_END) ? ST_INIT : ST_WFQ;
                cnt_d   = (s || cnt_q == DEB_END) ? '0 : cnt_inc;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
        dpb_d  = (state_q != ST_INIT) && (state_q != ST_WQ);
        scen_d = (state_q == ST_SCEN);
        mcen_d = (state_q == ST_SCEN) || (state_q == ST_MCEN);
    end

    // All channel state; reset clears outputs immediately, independent of clk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= ST_INIT;
            cnt_q   <= '0;
            dpb_q   <= 1'b0;
            scen_q  <= 1'b0;
            mcen_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dpb_q   <= dpb_d;
            scen_q  <= scen_d;
            mcen_q  <= mcen_d;
        end
    end

endmodule

// File: rtl/button_debounce_scen.sv
// button_debounce_scen: N independent debounced button channels with press and auto-repeat enables
module button_debounce_scen #(
    parameter int N_BTN        = 4,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] DPBs,
    output logic [N_BTN-1:0] SCENs,
    output logic [N_BTN-1:0] MCENs
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn_raw[i]),
            .dpb    (DPBs[i]),
            .scen   (SCENs[i]),
            .mcen   (MCENs[i])
        );
    end

endmodule

// File: tb/tb_button_debounce_scen.sv
// tb_button_debounce_scen: scoreboard bench for the debounced button front end
module tb_button_debounce_scen;

    typedef struct {
        int         cyc;
        logic [3:0] scen;
        logic [3:0] mcen;
    } ev_t;

    typedef struct {
        int         cyc;
        logic [3:0] dpb;
    } lv_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn_raw = 4'b0;
    logic [3:0] DPBs, SCENs, MCENs;
    int         cyc = 0;
    int         n_run = 0;
    int         n_fail = 0;
    bit         done = 1'b0;
    ev_t        ev_q[$];
    lv_t        lv_q[$];
    ev_t        e;
    lv_t        l;

    button_debounce_scen #(
        .N_BTN       (4),
        .DEBOUNCE_CYC(8),
        .REPEAT_DELAY(20),
        .REPEAT_RATE (5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_raw),
        .DPBs   (DPBs),
        .SCENs  (SCENs),
        .MCENs  (MCENs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected events for one clean press whose input edge is driven just after edge t0 and
    // released just after edge t0+rel: SCEN at +12, MCEN at +12, +33, +39, ... while the
    // synchronised input is still high, DPB falling 9 edges after the channel reaches WFQ.
    task automatic expect_press(input logic [3:0] m, input int t0, input int rel);
        int d, w;
        d = rel + 3;
        ev_q.push_back('{t0 + 12, m, m});
        for (int k = 0; 32 + 6 * k <= d - 1; k++) ev_q.push_back('{t0 + 33 + 6 * k, 4'b0, m});
        w = (d - 1 == 11 || (d - 1 >= 32 && (d - 1 - 32) % 6 == 0)) ? d + 1 : d;
        lv_q.push_back('{t0 + 12, m});
        lv_q.push_back('{t0 + w + 8, m});
        lv_q.push_back('{t0 + w + 9, 4'b0});
    endtask

    task automatic press(input logic [3:0] m, input int rel);
        int t0;
        @(negedge clk);
        btn_raw = btn_raw | m;
        t0 = cyc;
        expect_press(m, t0, rel);
        repeat (rel) @(negedge clk);
        btn_raw = btn_raw & ~m;
        repeat (20) @(negedge clk);
    endtask

    // Monitor: reset-state checks, pulse scoreboard, level checks, final drain and summary
    always begin
        @(negedge clk or negedge reset);
        if (!reset) begin
            #1;
            n_run++;
            if ({DPBs, SCENs, MCENs} !== 12'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got dpb=%b scen=%b mcen=%b exp all 0", cyc, DPBs, SCENs, MCENs);
            end
        end else begin
            if ((SCENs | MCENs) != 4'b0) begin
                n_run++;
                if (ev_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse cyc=%0d got scen=%b mcen=%b exp none", cyc, SCENs, MCENs);
                end else begin
                    e = ev_q.pop_front();
                    if (e.cyc != cyc || e.scen !== SCENs || e.mcen !== MCENs) begin
                        n_fail++;
                        $display("FAIL pulse got cyc=%0d scen=%b mcen=%b exp cyc=%0d scen=%b mcen=%b",
                                 cyc, SCENs, MCENs, e.cyc, e.scen, e.mcen);
                    end
                end
            end else if (ev_q.size() != 0 && ev_q[0].cyc <= cyc) begin
                e = ev_q.pop_front();
                n_run++;
                n_fail++;
                $display("FAIL missing_pulse cyc=%0d got none exp scen=%b mcen=%b", e.cyc, e.scen, e.mcen);
            end
            while (lv_q.size() != 0 && lv_q[0].cyc <= cyc) begin
                l = lv_q.pop_front();
                n_run++;
                if (l.cyc != cyc || DPBs !== l.dpb) begin
                    n_fail++;
                    $display("FAIL dpb_level cyc=%0d got %b exp %b at cyc %0d", cyc, DPBs, l.dpb, l.cyc);
                end
            end
        end
        if (cyc > 20000) begin
            $display("FAIL watchdog cyc=%0d exp done before 20000", cyc);
            $fatal(1, "watchdog");
        end
        if (done) begin
            n_run += ev_q.size() + lv_q.size();
            n_fail += ev_q.size() + lv_q.size();
            if (ev_q.size() + lv_q.size() != 0)
                $display("FAIL leftover got %0d pending exp 0", ev_q.size() + lv_q.size());
            $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
            $finish;
        end
    end

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        // clean press on button 0 held 100 cycles
        press(4'b0001, 100);
        // release lands exactly when the first repeat pulse is due: release wins
        press(4'b0001, 29);
        // release one cycle later: repeat pulse still fires
        press(4'b0001, 30);
        // bouncy press on button 2: 5 high, 1 low, then held
        @(negedge clk);
        btn_raw[2] = 1'b1;
        repeat (5) @(negedge clk);
        btn_raw[2] = 1'b0;
        @(negedge clk);
        btn_raw[2] = 1'b1;
        t0 = cyc;
        lv_q.push_back('{t0 + 11, 4'b0000});
        expect_press(4'b0100, t0, 25);
        repeat (25) @(negedge clk);
        btn_raw[2] = 1'b0;
        repeat (20) @(negedge clk);
        // short release glitch on button 1 while held
        @(negedge clk);
        btn_raw[1] = 1'b1;
        t0 = cyc;
        ev_q.push_back('{t0 + 12, 4'b0010, 4'b0010});
        lv_q.push_back('{t0 + 12, 4'b0010});
        lv_q.push_back('{t0 + 25, 4'b0010});
        lv_q.push_back('{t0 + 50, 4'b0010});
        lv_q.push_back('{t0 + 51, 4'b0000});
        repeat (15) @(negedge clk);
        btn_raw[1] = 1'b0;
        repeat (4) @(negedge clk);
        btn_raw[1] = 1'b1;
        repeat (21) @(negedge clk);
        btn_raw[1] = 1'b0;
        repeat (20) @(negedge clk);
        // simultaneous press on buttons 0 and 3
        press(4'b1001, 20);
        // asynchronous reset mid-HOLD, button kept held through reset release
        @(negedge clk);
        btn_raw[0] = 1'b1;
        t0 = cyc;
        ev_q.push_back('{t0 + 12, 4'b0001, 4'b0001});
        lv_q.push_back('{t0 + 12, 4'b0001});
        lv_q.push_back('{t0 + 20, 4'b0001});
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        t0 = cyc;
        expect_press(4'b0001, t0, 25);
        repeat (25) @(negedge clk);
        btn_raw[0] = 1'b0;
        repeat (20) @(negedge clk);
        done = 1'b1;
    end

endmodule
